// File: rtl/debounce_pkg.sv
// Shared types and defaults for the push-button level debouncer and its helpers.
package debounce_pkg;

    typedef enum logic [1:0] {
        LOW_STABLE  = 2'd0,
        WAIT_HIGH   = 2'd1,
        HIGH_STABLE = 2'd2,
        WAIT_LOW    = 2'd3
    } db_state_t;

    localparam int DB_STABLE_CYCLES = 64;
    localparam int DB_CNT_WIDTH     = 7;
    localparam int DB_PRESS_WIDTH   = 8;

endpackage

// File: rtl/level_debouncer_if.sv
// Button-side bundle: raw level in, conditioned level, edge pulses and press count out.
interface level_debouncer_if;
    import debounce_pkg::*;

    logic                      noisy_level;
    logic                      clean_level;
    logic                      rise_pulse;
    logic                      fall_pulse;
    logic [DB_PRESS_WIDTH-1:0] press_count;

    modport master (
        output noisy_level,
        input  clean_level,
        input  rise_pulse,
        input  fall_pulse,
        input  press_count
    );

    modport slave (
        input  noisy_level,
        output clean_level,
        output rise_pulse,
        output fall_pulse,
        output press_count
    );

endinterface

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchroniser for asynchronous pad inputs; clears to 0 on reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic sync1_r;
    logic sync2_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= d;
            sync2_r <= sync1_r;
        end
    end

    assign q = sync2_r;

endmodule

// File: rtl/level_debouncer.sv
// Debounces a raw button level: synchronise, require STABLE_CYCLES of a new level,
// then emit a clean level, one-cycle rise/fall pulses and a wrapping press count.
module level_debouncer
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DB_STABLE_CYCLES,
    parameter int CNT_WIDTH     = DB_CNT_WIDTH
) (
    input logic               clk,
    input logic               rst,
    level_debouncer_if.slave  bus
);

    localparam logic [CNT_WIDTH-1:0] STABLE_LIM = CNT_WIDTH'(STABLE_CYCLES);

    logic                      sync2_s;
    db_state_t                 state_r;
    db_state_t                 state_nx_s;
    logic [CNT_WIDTH-1:0]      cnt_r;
    logic [CNT_WIDTH-1:0]      cnt_nx_s;
    logic [CNT_WIDTH-1:0]      cnt_inc_s;
    logic                      clean_r;
    logic                      clean_nx_s;
    logic                      rise_r;
    logic                      rise_nx_s;
    logic                      fall_r;
    logic                      fall_nx_s;
    logic [DB_PRESS_WIDTH-1:0] press_r;
    logic [DB_PRESS_WIDTH-1:0] press_nx_s;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (bus.noisy_level),
        .q   (sync2_s)
    );

    assign cnt_inc_s = cnt_r + CNT_WIDTH'(1);

    // Filter next-state: any cycle agreeing with the clean level drops all accumulated credit.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        clean_nx_s = clean_r;
        rise_nx_s  = 1'b0;
        fall_nx_s  = 1'b0;
        press_nx_s = press_r;
        case (state_r)
            LOW_STABLE, WAIT_HIGH: begin
                if (sync2_s == 1'b0) begin
                    state_nx_s = LOW_STABLE;
                    cnt_nx_s   = {CNT_WIDTH{1'b0}};
                end else if (cnt_inc_s == STABLE_LIM) begin
                    state_nx_s = HIGH_STABLE;
                    cnt_nx_s   = {CNT_WIDTH{1'b0}};
                    clean_nx_s = 1'b1;
                    rise_nx_s  = 1'b1;
                    press_nx_s = press_r + 8'd1;
                end else begin
                    state_nx_s = WAIT_HIGH;
                    cnt_nx_s   = cnt_inc_s;
                end
            end
            HIGH_STABLE, WAIT_LOW: begin
                if (sync2_s == 1'b1) begin
                    state_nx_s = HIGH_STABLE;
                    cnt_nx_s   = {CNT_WIDTH{1'b0}};
                end else if (cnt_inc_s == STABLE_LIM) begin
                    state_nx_s = LOW_STABLE;
                    cnt_nx_s   = {CNT_WIDTH{1'b0}};
                    clean_nx_s = 1'b0;
                    fall_nx_s  = 1'b1;
                end else begin
                    state_nx_s = WAIT_LOW;
                    cnt_nx_s   = cnt_inc_s;
                end
            end
            default: begin
                state_nx_s = LOW_STABLE;
                cnt_nx_s   = {CNT_WIDTH{1'b0}};
                clean_nx_s = 1'b0;
            end
        endcase
    end

    // State, counter and all outputs registered together; reset wins over acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= LOW_STABLE;
            cnt_r   <= {CNT_WIDTH{1'b0}};
            clean_r <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
            press_r <= 8'd0;
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            clean_r <= clean_nx_s;
            rise_r  <= rise_nx_s;
            fall_r  <= fall_nx_s;
            press_r <= press_nx_s;
        end
    end

    assign bus.clean_level = clean_r;
    assign bus.rise_pulse  = rise_r;
    assign bus.fall_pulse  = fall_r;
    assign bus.press_count = press_r;

endmodule

// File: tb/tb_level_debouncer.sv
// Self-checking bench for level_debouncer: sliding-window reference model plus directed
// and randomised button traffic.
module tb_level_debouncer;

    localparam int N = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;

    level_debouncer_if bus_if ();

    level_debouncer #(
        .STABLE_CYCLES (N),
        .CNT_WIDTH     (7)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference: a level is accepted once the last N filter-visible samples all differ from it.
    bit         m_s1 = 1'b0;
    bit         m_s2 = 1'b0;
    bit         m_clean = 1'b0;
    bit         m_rise = 1'b0;
    bit         m_fall = 1'b0;
    logic [7:0] m_press = 8'd0;
    bit         hist[$];

    int rise_seen = 0;
    int fall_seen = 0;
    int last_rise = -1;
    int last_fall = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_edge(input bit lvl, input bit r);
        bit all_diff;
        if (r) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_clean = 1'b0;
            m_rise = 1'b0; m_fall = 1'b0; m_press = 8'd0;
            hist.delete();
        end else begin
            hist.push_back(m_s2);
            if (hist.size() > N) void'(hist.pop_front());
            m_s2 = m_s1;
            m_s1 = lvl;
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (hist.size() == N) begin
                all_diff = 1'b1;
                foreach (hist[i]) if (hist[i] == m_clean) all_diff = 1'b0;
                if (all_diff) begin
                    m_clean = !m_clean;
                    if (m_clean) begin
                        m_rise  = 1'b1;
                        m_press = m_press + 8'd1;
                    end else begin
                        m_fall = 1'b1;
                    end
                end
            end
        end
    endtask

    task automatic step(input bit lvl, input bit r);
        @(negedge clk);
        bus_if.noisy_level = lvl;
        rst = r;
        @(posedge clk);
        model_edge(lvl, r);
        cyc++;
        #1;
        chk("clean_level", 32'(bus_if.clean_level), 32'(m_clean));
        chk("rise_pulse",  32'(bus_if.rise_pulse),  32'(m_rise));
        chk("fall_pulse",  32'(bus_if.fall_pulse),  32'(m_fall));
        chk("press_count", 32'(bus_if.press_count), 32'(m_press));
        if (bus_if.rise_pulse === 1'b1) begin rise_seen++; last_rise = cyc; end
        if (bus_if.fall_pulse === 1'b1) begin fall_seen++; last_fall = cyc; end
    endtask

    task automatic hold(input bit lvl, input int n);
        repeat (n) step(lvl, 1'b0);
    endtask

    initial begin
        int k;
        int r0;
        int f0;
        logic [7:0] p0;
        bus_if.noisy_level = 1'b0;
        rst = 1'b1;

        // Reset held with the input low.
        repeat (20) step(1'b0, 1'b1);
        chk("reset_press", 32'(bus_if.press_count), 32'd0);
        chk("reset_rises", 32'(rise_seen), 32'd0);

        // Single-cycle glitch must be swallowed.
        hold(1'b1, 1);
        hold(1'b0, 40);
        chk("glitch_rises", 32'(rise_seen), 32'd0);
        chk("glitch_clean", 32'(bus_if.clean_level), 32'd0);

        // Clean press: pulses 65 edges after the new level is first sampled.
        r0 = rise_seen;
        hold(1'b1, 1);
        k = cyc;
        hold(1'b1, 100);
        chk("press_rise_latency", 32'(last_rise - k), 32'd65);
        chk("press_rise_count", 32'(rise_seen - r0), 32'd1);
        chk("press_count_1", 32'(bus_if.press_count), 32'd1);
        hold(1'b0, 1);
        k = cyc;
        hold(1'b0, 99);
        chk("release_fall_latency", 32'(last_fall - k), 32'd65);

        // Bouncy press and bouncy release.
        r0 = rise_seen; f0 = fall_seen; p0 = bus_if.press_count;
        for (int i = 0; i < 10; i++) hold((i % 2) == 0, 3);
        hold(1'b1, 100);
        for (int i = 0; i < 7; i++) hold((i % 2) == 1, 3);
        hold(1'b0, 100);
        chk("bouncy_rises", 32'(rise_seen - r0), 32'd1);
        chk("bouncy_falls", 32'(fall_seen - f0), 32'd1);
        chk("bouncy_press", 32'(bus_if.press_count), 32'(p0 + 8'd1));

        // Reset in the middle of WAIT_HIGH with the input held high.
        r0 = rise_seen;
        hold(1'b1, 42);
        step(1'b1, 1'b1);
        step(1'b1, 1'b1);
        chk("midreset_no_rise", 32'(rise_seen - r0), 32'd0);
        chk("midreset_press0", 32'(bus_if.press_count), 32'd0);
        hold(1'b1, 1);
        k = cyc;
        hold(1'b1, 99);
        chk("midreset_rise_latency", 32'(last_rise - k), 32'd65);
        chk("midreset_press1", 32'(bus_if.press_count), 32'd1);
        hold(1'b0, 100);

        // 256 clean presses wrap the counter back to zero.
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        r0 = rise_seen; f0 = fall_seen;
        repeat (256) begin
            hold(1'b1, 70);
            hold(1'b0, 70);
        end
        chk("wrap_press", 32'(bus_if.press_count), 32'd0);
        chk("wrap_rises", 32'(rise_seen - r0), 32'd256);
        chk("wrap_falls", 32'(fall_seen - f0), 32'd256);

        // Random bursts with occasional resets, checked cycle by cycle against the model.
        repeat (60) begin
            if ($urandom_range(0, 14) == 0) begin
                repeat ($urandom_range(1, 3)) step(1'($urandom_range(0, 1)), 1'b1);
            end else begin
                hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 120)));
            end
        end
        hold(1'b0, 80);
        chk("final_clean", 32'(bus_if.clean_level), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
